// File: rtl/sc_fifo_reader.sv
// Read-side drain for sc_fifo: turns rdreq/empty/q into a registered valid/ready stream.
// Optional delivered-word counter on word_count is built when SC_FIFO_READER_STATS_EN is defined.
module sc_fifo_reader #(
  parameter int DWIDTH    = 8,
  parameter int BUF_DEPTH = 3
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_q,
  output logic              fifo_rdreq,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic [31:0]       word_count
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam logic [OCC_W:0]   DEPTH_LIMIT = (OCC_W + 1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(BUF_DEPTH - 1);

  logic [DWIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_next;
  logic              inflight;
  logic              pop;
  logic [OCC_W:0]    pending;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // A read is only issued when the word it returns is guaranteed a slot,
  // counting the word that may already be on its way back from the FIFO.
  assign pending    = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign fifo_rdreq = !rst && !fifo_empty && (pending < DEPTH_LIMIT);

  assign out_valid = (occ != '0);
  assign out_data  = buf_mem[rd_ptr];
  assign pop       = out_valid && out_ready;

  always_comb begin
    occ_next = occ;
    case ({inflight, pop})
      2'b10:   occ_next = occ + OCC_W'(1);
      2'b01:   occ_next = occ - OCC_W'(1);
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      occ      <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= fifo_rdreq;
      occ      <= occ_next;
      if (inflight) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Storage needs no reset; a word written while rst is high is never made visible.
  always_ff @(posedge clock) begin
    if (inflight) begin
      buf_mem[wr_ptr] <= fifo_q;
    end
  end

`ifdef SC_FIFO_READER_STATS_EN
  logic [31:0] word_cnt;

  always_ff @(posedge clock) begin
    if (rst) begin
      word_cnt <= 32'd0;
    end else if (pop) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end

  assign word_count = word_cnt;
`else
  assign word_count = 32'd0;
`endif

endmodule

// File: tb/tb_sc_fifo_reader.sv
// Self-checking bench for sc_fifo_reader with a behavioural sc_fifo model (read latency 1).
// Directed vector tables plus hand-written reset and random-traffic sequences.
module tb_sc_fifo_reader;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_q = 8'h00;
  logic        fifo_rdreq;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic [31:0] word_count;

  always #5 clock = ~clock;

  sc_fifo_reader #(.DWIDTH(8), .BUF_DEPTH(3)) dut (
    .clock      (clock),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .word_count (word_count)
  );

  typedef struct {
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_rdreq;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  logic [7:0] fifo_mem[$];
  logic       wr_req = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] head;
  logic [7:0] exp_q[$];
  bit         sb_en = 1'b0;
  int         popped = 0;
  int         outstanding = 0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  vec_t       stall_vec[19];

  // sc_fifo model: q is valid the cycle after rdreq, empty is registered
  always @(posedge clock) begin
    if (fifo_rdreq && fifo_mem.size() > 0) begin
      head = fifo_mem.pop_front();
      fifo_q <= head;
    end
    if (wr_req) fifo_mem.push_back(wr_data);
    fifo_empty <= (fifo_mem.size() == 0);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic rdy);
    rst       = r;
    out_ready = rdy;
    #1;
  endtask

  // Per-cycle protocol checks; also tracks reads issued but not yet delivered
  task automatic monitor();
    bit         do_pop;
    logic [7:0] exp_w;
    if (fifo_empty) check_output("rdreq_on_empty", {31'd0, fifo_rdreq}, 32'd0);
    check_output("occ_bound", {31'd0, (outstanding <= 3)}, 32'd1);
    if (prev_hold) begin
      check_output("hold_valid", {31'd0, out_valid}, 32'd1);
      check_output("hold_data", {24'd0, out_data}, {24'd0, prev_data});
    end
    do_pop = out_valid && out_ready && !rst;
    if (sb_en && do_pop) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_extra: got 0x%0h, expected no word", out_data);
      end else begin
        exp_w = exp_q.pop_front();
        check_output("sb_data", {24'd0, out_data}, {24'd0, exp_w});
        popped++;
      end
    end
    if (rst) outstanding = 0;
    else     outstanding = outstanding + int'(fifo_rdreq) - int'(do_pop);
    prev_hold = out_valid && !out_ready && !rst;
    prev_data = out_data;
  endtask

  task automatic next_cycle();
    monitor();
    @(negedge clock);
  endtask

  task automatic reset_and_load(input int n, input logic [7:0] first);
    rst       = 1'b1;
    out_ready = 1'b0;
    wr_req    = 1'b0;
    sb_en     = 1'b0;
    fifo_mem.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) fifo_mem.push_back(first + 8'(i));
    repeat (2) begin
      #1;
      next_cycle();
    end
  endtask

  initial begin
    int pulses;
    int written;
    int cyc;
    logic exp_v;

    stall_vec[0]  = '{1'b0, 1'b0, 8'h00, 1'b1};
    stall_vec[1]  = '{1'b0, 1'b0, 8'h00, 1'b1};
    stall_vec[2]  = '{1'b0, 1'b1, 8'h01, 1'b1};
    for (int i = 3; i < 10; i++) stall_vec[i] = '{1'b0, 1'b1, 8'h01, 1'b0};
    stall_vec[10] = '{1'b1, 1'b1, 8'h01, 1'b0};
    stall_vec[11] = '{1'b1, 1'b1, 8'h02, 1'b1};
    stall_vec[12] = '{1'b1, 1'b1, 8'h03, 1'b1};
    stall_vec[13] = '{1'b1, 1'b1, 8'h04, 1'b1};
    stall_vec[14] = '{1'b1, 1'b1, 8'h05, 1'b1};
    stall_vec[15] = '{1'b1, 1'b1, 8'h06, 1'b1};
    stall_vec[16] = '{1'b1, 1'b1, 8'h07, 1'b0};
    stall_vec[17] = '{1'b1, 1'b1, 8'h08, 1'b0};
    stall_vec[18] = '{1'b1, 1'b0, 8'h00, 1'b0};

    @(negedge clock);

    // Reset and idle with an empty FIFO
    for (int n = 0; n < 6; n++) begin
      apply_stimulus((n < 3), 1'b0);
      check_output($sformatf("idle_valid[%0d]", n), {31'd0, out_valid}, 32'd0);
      check_output($sformatf("idle_rdreq[%0d]", n), {31'd0, fifo_rdreq}, 32'd0);
      check_output($sformatf("idle_count[%0d]", n), word_count, 32'd0);
      next_cycle();
    end

    // Burst of 16 preloaded words with a consumer that never stalls
    reset_and_load(16, 8'h01);
    for (int n = 0; n < 20; n++) begin
      apply_stimulus(1'b0, 1'b1);
      exp_v = (n >= 2) && (n <= 17);
      check_output($sformatf("burst_valid[%0d]", n), {31'd0, out_valid}, {31'd0, exp_v});
      if (exp_v) check_output($sformatf("burst_data[%0d]", n), {24'd0, out_data}, 32'(n - 1));
      check_output($sformatf("burst_rdreq[%0d]", n), {31'd0, fifo_rdreq}, {31'd0, (n <= 15)});
      next_cycle();
    end
`ifdef SC_FIFO_READER_STATS_EN
    apply_stimulus(1'b0, 1'b0);
    check_output("burst_count", word_count, 32'd16);
`else
    apply_stimulus(1'b0, 1'b0);
    check_output("burst_count_tied", word_count, 32'd0);
`endif
    next_cycle();

    // Stall for 10 cycles with 8 words waiting, then drain
    reset_and_load(8, 8'h01);
    pulses = 0;
    for (int n = 0; n < 19; n++) begin
      apply_stimulus(1'b0, stall_vec[n].ready);
      check_output($sformatf("stall_valid[%0d]", n), {31'd0, out_valid}, {31'd0, stall_vec[n].exp_valid});
      if (stall_vec[n].exp_valid)
        check_output($sformatf("stall_data[%0d]", n), {24'd0, out_data}, {24'd0, stall_vec[n].exp_data});
      check_output($sformatf("stall_rdreq[%0d]", n), {31'd0, fifo_rdreq}, {31'd0, stall_vec[n].exp_rdreq});
      if (n < 10 && fifo_rdreq) pulses++;
      next_cycle();
    end
    check_output("stall_pulses", 32'(pulses), 32'd3);

    // Reset while two words are buffered and one is in flight
    reset_and_load(8, 8'h20);
    for (int n = 0; n < 3; n++) begin
      apply_stimulus(1'b0, 1'b0);
      next_cycle();
    end
    apply_stimulus(1'b1, 1'b0);
    check_output("prerst_valid", {31'd0, out_valid}, 32'd1);
    check_output("prerst_data", {24'd0, out_data}, 32'h20);
    next_cycle();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h23 + 8'(i));
    sb_en = 1'b1;
    apply_stimulus(1'b0, 1'b1);
    check_output("postrst_valid", {31'd0, out_valid}, 32'd0);
    next_cycle();
    apply_stimulus(1'b0, 1'b1);
    check_output("resume_gap", {31'd0, out_valid}, 32'd0);
    next_cycle();
    apply_stimulus(1'b0, 1'b1);
    check_output("resume_valid", {31'd0, out_valid}, 32'd1);
    check_output("resume_data", {24'd0, out_data}, 32'h23);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      next_cycle();
      apply_stimulus(1'b0, 1'b1);
      cyc++;
    end
    check_output("resume_drained", 32'(exp_q.size()), 32'd0);
    next_cycle();

    // Random upstream writes and random consumer stalls, 1000 words
    reset_and_load(0, 8'h00);
    sb_en   = 1'b1;
    popped  = 0;
    written = 0;
    cyc     = 0;
    while (popped < 1000 && cyc < 20000) begin
      rst       = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      wr_req    = (written < 1000) && ($urandom_range(0, 99) < 60);
      if (wr_req) begin
        wr_data = 8'($urandom);
        exp_q.push_back(wr_data);
        written++;
      end
      #1;
      next_cycle();
      cyc++;
    end
    wr_req = 1'b0;
    check_output("rand_words", 32'(popped), 32'd1000);
    sb_en = 1'b0;

`ifdef SC_FIFO_READER_STATS_EN
    // Counter wrap from 0xFFFFFFFE through three pops
    reset_and_load(3, 8'h40);
    for (int n = 0; n < 4; n++) begin
      apply_stimulus(1'b0, 1'b0);
      next_cycle();
    end
    force dut.word_cnt = 32'hFFFF_FFFE;
    apply_stimulus(1'b0, 1'b0);
    next_cycle();
    release dut.word_cnt;
    apply_stimulus(1'b0, 1'b0);
    check_output("wrap_start", word_count, 32'hFFFF_FFFE);
    next_cycle();
    for (int n = 0; n < 3; n++) begin
      apply_stimulus(1'b0, 1'b1);
      next_cycle();
    end
    apply_stimulus(1'b0, 1'b0);
    check_output("wrap_end", word_count, 32'h0000_0001);
    next_cycle();
`else
    apply_stimulus(1'b0, 1'b0);
    check_output("count_tied_end", word_count, 32'd0);
    next_cycle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_fifo_reader.md
Name: sc_fifo_reader

Overview:
- Read-side drain for the single-clock `sc_fifo` (standard mode, read latency 1, `q` valid the cycle after `rdreq`).
- Converts the FIFO's `rdreq`/`empty`/`q` interface into a valid/ready stream with registered outputs.
- Sustains one word per cycle with no combinational path from `out_ready` to `fifo_rdreq`.
- Sits between any `sc_fifo` instance and a downstream consumer that may stall at any cycle.

Parameters:
- DWIDTH, 8, word width; must match the attached `sc_fifo` DWIDTH.
- BUF_DEPTH, 3, internal output-buffer entries; fixed minimum 3 for full throughput; values below 3 are illegal.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  `empty` from `sc_fifo`.
- fifo_q  in  DWIDTH  `q` from `sc_fifo`; sampled only the cycle after an issued read.
- fifo_rdreq  out  1  `rdreq` to `sc_fifo`.
- out_valid  out  1  `out_data` holds a valid word.
- out_data  out  DWIDTH  head word of the internal buffer.
- out_ready  in  1  consumer accepts the word when high together with `out_valid`.
- word_count  out  32  words delivered (see Optional Feature).

Behaviour:
- State: circular buffer of BUF_DEPTH entries; `rd_ptr`, `wr_ptr` (wrap at BUF_DEPTH); `occ` (0..BUF_DEPTH); `inflight` flag (one read issued last cycle).
- Issue rule (registered state only): `fifo_rdreq = !rst && !fifo_empty && (occ + inflight) < BUF_DEPTH`.
- Capture: `inflight` <= `fifo_rdreq` each cycle.
  - When `inflight` = 1, write `fifo_q` at `wr_ptr` and advance `wr_ptr`.
  - Capture is unconditional; the issue rule guarantees space.
- Pop: `out_valid && out_ready` advances `rd_ptr`.
- Occupancy: `occ_next = occ + inflight - pop`. A simultaneous capture and pop leaves `occ` unchanged and both pointers advance.
- `out_valid = (occ != 0)`; `out_data = buf[rd_ptr]`, driven straight from registers (registered outputs).
- Latency: the first word reaches `out_valid` 2 cycles after `fifo_empty` falls (1 cycle issue→q, 1 cycle capture).
- Throughput: steady state is `occ` = 1 with `inflight` = 1, giving 1 word/cycle while `out_ready` = 1.
- Stall: with `out_ready` = 0, at most BUF_DEPTH words are buffered or in flight; `fifo_rdreq` stays low until space frees. No overflow, no drop.
- Empty: when `fifo_empty` = 1, `fifo_rdreq` = 0. The FIFO's read-on-empty tolerance is not relied on.
- `out_data` holds stable while `out_valid && !out_ready`. `out_valid` never drops without a pop.
- Reset values: `occ` = 0, `inflight` = 0, pointers = 0, `out_valid` = 0, `fifo_rdreq` = 0, `word_count` = 0. `out_data` is don't-care.
- Reset mid-operation: buffered words and any in-flight word are discarded. `sc_fifo` has no reset, so a word popped the cycle before `rst` is lost by design. After `rst` falls, reads resume from the FIFO's current head.
- Width rules:
  - `occ`: `$clog2(BUF_DEPTH+1)` bits.
  - Pointers: `$clog2(BUF_DEPTH)` bits with explicit wrap at BUF_DEPTH-1 → 0.

Optional Feature:
- Macro: SC_FIFO_READER_STATS_EN.
- Defined: `word_count` increments by 1 on every `out_valid && out_ready`, wraps modulo 2^32, and clears on `rst`.
- Undefined: `word_count` is tied to 32'd0 and no counter logic is built. The port list is identical in both builds.

Test Plan:
- Reset with `fifo_empty` = 1 → `out_valid` = 0, `fifo_rdreq` = 0, `word_count` = 0 for all cycles.
- FIFO preloaded with 0x01..0x10, `out_ready` = 1 → first `out_valid` 2 cycles after reset release, then 16 consecutive beats 0x01..0x10 with no bubbles; `word_count` = 16 (STATS build).
- 8 words preloaded, `out_ready` = 0 for 10 cycles → exactly 3 `fifo_rdreq` pulses, `out_data` held at 0x01; on release, words 0x01..0x08 arrive in order with none lost or duplicated.
- Random `out_ready` (50%) with random upstream writes, 1000 words → output sequence matches write order; `fifo_rdreq` never high while `fifo_empty` = 1; `occ` + `inflight` ≤ 3 every cycle.
- `rst` asserted for 1 cycle while `occ` = 2 and `inflight` = 1 → next cycle `out_valid` = 0. Output resumes with the FIFO's next unread word; the 3 discarded words never appear.
- STATS build: force `word_count` to 0xFFFFFFFE, then 3 pops → counter reads 0x00000001.
